// File: rtl/fetch_queue.sv
// DEPTH-entry instruction queue between fetch and decode.
// Fetch pushes {instr, PC} pairs, decode pops the head, and a bubble empties the queue in one cycle.
module fetch_queue #(
   parameter int                     INSTR_WIDTH = 32,
   parameter int                     PC_WIDTH    = 32,
   parameter int                     DEPTH       = 4,
   parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       F_bubble_i,
   input  logic                       F_valid_i,
   output logic                       F_ready_o,
   input  logic [INSTR_WIDTH-1:0]     instr_i,
   input  logic [PC_WIDTH-1:0]        F_PC_i,
   input  logic                       D_stall_i,
   output logic                       FD_valid_o,
   output logic [INSTR_WIDTH-1:0]     FD_instr_o,
   output logic [PC_WIDTH-1:0]        FD_PC_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int                PTR_W    = $clog2(DEPTH);
   localparam int                CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

   logic [INSTR_WIDTH-1:0] instr_mem_q [DEPTH];
   logic [INSTR_WIDTH-1:0] instr_mem_d [DEPTH];
   logic [PC_WIDTH-1:0]    pc_mem_q    [DEPTH];
   logic [PC_WIDTH-1:0]    pc_mem_d    [DEPTH];

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   logic full;
   logic empty;
   logic push;
   logic pop;

   // Ready and valid come only from registered count, so decode stall never reaches F_ready_o.
   assign full       = (count_q == FULL_CNT);
   assign empty      = (count_q == '0);
   assign F_ready_o  = ~full;
   assign FD_valid_o = ~empty;
   assign count_o    = count_q;

   assign push = F_valid_i & ~full & ~F_bubble_i;
   assign pop  = ~empty & ~D_stall_i & ~F_bubble_i;

   assign FD_instr_o = empty ? NOP_INSTR     : instr_mem_q[rd_ptr_q];
   assign FD_PC_o    = empty ? PC_WIDTH'(0)  : pc_mem_q[rd_ptr_q];

   always_comb begin
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      instr_mem_d = instr_mem_q;
      pc_mem_d    = pc_mem_q;

      if (F_bubble_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            instr_mem_d[wr_ptr_q] = instr_i;
            pc_mem_d[wr_ptr_q]    = F_PC_i;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; an empty queue masks whatever it holds.
   always_ff @(posedge clk_i) begin
      instr_mem_q <= instr_mem_d;
      pc_mem_q    <= pc_mem_d;
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the single-entry fetch/decode pipeline register: a DEPTH-entry instruction queue between fetch and decode.
- Fetch pushes {instr, PC} pairs with a valid/ready handshake. Decode consumes the head entry unless it stalls.
- A flush (bubble) input empties the queue in one cycle for branch redirect.
- The head is presented as a NOP (instr = NOP_INSTR, PC = 0) with valid low whenever the queue is empty.

Parameters:
INSTR_WIDTH, 32, instruction width in bits
PC_WIDTH, 32, PC width in bits
DEPTH, 4, number of entries; power of two, >= 2
NOP_INSTR, 0, instruction value driven on FD_instr_o when the queue is empty or after flush

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
F_bubble_i  in  1  flush: discard all entries, the same-cycle push and the same-cycle pop
F_valid_i  in  1  fetch presents a valid instr/PC pair
F_ready_o  out  1  queue can accept a push this cycle
instr_i  in  INSTR_WIDTH  fetched instruction
F_PC_i  in  PC_WIDTH  PC of the fetched instruction
D_stall_i  in  1  decode stall: head is not consumed this cycle
FD_valid_o  out  1  head entry valid
FD_instr_o  out  INSTR_WIDTH  head instruction, NOP_INSTR when empty
FD_PC_o  out  PC_WIDTH  head PC, 0 when empty
count_o  out  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH

Behaviour:
- Reset (rst_n_i low, asynchronous, takes effect mid-operation at any time):
  - read pointer, write pointer and count = 0
  - FD_valid_o = 0, FD_instr_o = NOP_INSTR, FD_PC_o = 0, F_ready_o = 1
  - storage array contents are don't-care.
- Handshake:
  - push = F_valid_i & F_ready_o & ~F_bubble_i
  - pop = FD_valid_o & ~D_stall_i & ~F_bubble_i
  - F_ready_o = (count_o != DEPTH). It is registered-state-derived and does not depend on same-cycle pop; no combinational path from D_stall_i to F_ready_o.
  - FD_valid_o = (count_o != 0).
  - FD_instr_o / FD_PC_o = storage[rd_ptr] when valid, else NOP_INSTR / 0.
- Latency: an entry pushed at edge N is visible at the head after edge N if the queue was empty. No same-cycle bypass from instr_i to the outputs.
- Count update on each rising edge:
  - push & ~pop: +1
  - pop & ~push: -1
  - both or neither: unchanged.
- Pointers:
  - write pointer advances on push, read pointer on pop.
  - Both are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
- Full (count = DEPTH):
  - F_ready_o = 0; a push is refused even if a pop occurs in the same cycle.
  - Fetch must hold F_valid_i/instr_i/F_PC_i until accepted.
- Empty (count = 0): pop cannot occur; D_stall_i is ignored.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance, FIFO order preserved.
- F_bubble_i has highest priority after reset. At the next edge:
  - count = 0 and rd_ptr = wr_ptr = 0
  - the same-cycle push is dropped, pop is suppressed.
  - Outputs show NOP / valid 0 on the following cycle.
- D_stall_i with a valid head: outputs hold exactly and count is non-decreasing.
- Entry order is strictly FIFO; no entry is duplicated or lost except by flush or reset.

Test Plan:
- Reset then idle: assert rst_n_i=0 mid-cycle -> outputs immediately FD_valid_o=0, FD_instr_o=0, FD_PC_o=0, count_o=0, F_ready_o=1.
- Single push: instr_i=0x00500093, F_PC_i=0x100 pushed with D_stall_i=1 -> next cycle FD_valid_o=1, FD_instr_o=0x00500093, FD_PC_o=0x100, count_o=1.
- Fill to full: with D_stall_i=1, push PCs 0x100, 0x104, 0x108, 0x10C, then attempt 0x110:
  - count_o=4, F_ready_o=0, 0x110 not accepted.
  - Release stall -> heads 0x100, 0x104, 0x108, 0x10C in consecutive cycles, then 0x110 once re-presented and accepted.
- Streaming wrap-around: continuous push and pop for 10 instructions PCs 0x200..0x224 -> count_o stays 1, outputs in order with 1-cycle latency, pointers wrap past DEPTH without loss.
- Flush: queue holding 3 entries, F_bubble_i=1 with a concurrent push of 0x300 and D_stall_i=0 -> next cycle count_o=0, FD_valid_o=0, FD_instr_o=NOP_INSTR, FD_PC_o=0; 0x300 never appears at the head.
- Reset mid-operation: count_o=2, pulse rst_n_i low between clock edges -> outputs clear asynchronously; after release a new push of 0x400 appears alone at the head.
